// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_pkg
// Description : Shared definitions for the instruction-memory boot loader:
//               loader state encoding, instruction word width (same as the
//               processor's instruction width) and the default pad word.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

    // Instruction word width, shared with the processor datapath.
    localparam int c_WORD_W = 32;

    // Default pad word written behind the program.
    localparam logic [c_WORD_W-1:0] c_NOP_DEFAULT = 32'h0000_0000;

    // Loader states, explicitly encoded.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } boot_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Boot-time program loader. Holds the core in reset, streams
//               32-bit instruction words from a valid/ready port into
//               instruction memory starting at address 0, optionally pads
//               the unused tail with NOP_WORD, then releases core_reset after
//               RELEASE_DELAY cycles. A reload request in RUN restarts it.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               s_valid/s_data/s_last/s_ready - program word stream
//               reload           - restart request, honoured only in RUN
//               imem_we/imem_addr/imem_wdata  - registered memory write port
//               core_reset       - active-high reset to the processor
//               word_count       - program words accepted
//               load_error       - sticky overflow flag (no s_last seen)
//               busy             - high in every state except RUN
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int                    ADDR_W        = 10,
    parameter int                    DEPTH         = 1024,
    parameter logic [c_WORD_W-1:0]   NOP_WORD      = c_NOP_DEFAULT,
    parameter bit                    FILL_EN       = 1'b1,
    parameter int                    RELEASE_DELAY = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    input  logic [c_WORD_W-1:0] s_data,
    input  logic                s_last,
    output logic                s_ready,
    input  logic                reload,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [c_WORD_W-1:0] imem_wdata,
    output logic                core_reset,
    output logic [ADDR_W:0]     word_count,
    output logic                load_error,
    output logic                busy
);

    localparam int                c_DLY_W     = $clog2(RELEASE_DELAY + 1);
    localparam logic [c_DLY_W-1:0] c_DLY_INIT = c_DLY_W'(RELEASE_DELAY);
    localparam logic [c_DLY_W-1:0] c_DLY_ONE  = c_DLY_W'(1);
    localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    boot_state_t         r_state;
    logic                r_core_reset;
    logic                r_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_WORD_W-1:0] r_wdata;
    logic [ADDR_W:0]     r_count;
    logic                r_error;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_fill_addr;
    logic [c_DLY_W-1:0]  r_dly;

    logic                w_accept;
    logic [ADDR_W:0]     w_count_nxt;
    logic                w_at_top;
    logic                w_end;
    logic                w_fill_next;

    // s_ready is only ever high in LOAD, so no separate state qualifier.
    assign w_accept    = s_valid & r_ready;
    assign w_count_nxt = r_count + c_CNT_ONE;
    // In LOAD the count is always below DEPTH, so this marks the final slot.
    assign w_at_top    = (r_count == {1'b0, c_LAST_ADDR});
    assign w_end       = s_last | w_at_top;
    assign w_fill_next = FILL_EN && (w_count_nxt != c_DEPTH_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LOAD;
            r_core_reset <= 1'b1;
            r_ready      <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_count      <= '0;
            r_error      <= 1'b0;
            r_busy       <= 1'b1;
            r_fill_addr  <= '0;
            r_dly        <= '0;
        end else begin
            // Write enable is a single-cycle strobe unless re-armed below.
            r_we <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_count[ADDR_W-1:0];
                        r_wdata <= s_data;
                        r_count <= w_count_nxt;
                        if (w_end) begin
                            r_ready <= 1'b0;
                            if (!s_last) begin
                                r_error <= 1'b1;
                            end
                            if (w_fill_next) begin
                                r_state     <= FILL;
                                r_fill_addr <= w_count_nxt[ADDR_W-1:0];
                            end else begin
                                r_state <= HOLD;
                                r_dly   <= c_DLY_INIT;
                            end
                        end
                    end
                end
                FILL: begin
                    r_we    <= 1'b1;
                    r_addr  <= r_fill_addr;
                    r_wdata <= NOP_WORD;
                    if (r_fill_addr == c_LAST_ADDR) begin
                        r_state <= HOLD;
                        r_dly   <= c_DLY_INIT;
                    end else begin
                        r_fill_addr <= r_fill_addr + c_ADDR_ONE;
                    end
                end
                HOLD: begin
                    // Counter loaded with RELEASE_DELAY; release on the edge
                    // where it would reach zero.
                    if (r_dly == c_DLY_ONE) begin
                        r_state      <= RUN;
                        r_core_reset <= 1'b0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_dly <= r_dly - c_DLY_ONE;
                    end
                end
                RUN: begin
                    if (reload) begin
                        r_state      <= LOAD;
                        r_core_reset <= 1'b1;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_count      <= '0;
                        r_error      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign s_ready    = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign word_count = r_count;
    assign load_error = r_error;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader. Program loads are
//               described by a table of records; every expected memory write
//               is queued when stimulus is driven and compared when the DUT
//               presents it. Reload, ignored-reload and asynchronous reset
//               mid-fill are covered by hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int c_DEPTH = 1024;
    localparam int c_BOUND = 3000;

    logic        clk;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic [10:0] word_count;
    logic        load_error;
    logic        busy;

    imem_boot_loader dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .word_count (word_count),
        .load_error (load_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected memory writes.
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write", 64'({imem_addr, imem_wdata}), 64'({mon_e.addr, mon_e.data}));
            end
        end
    end

    typedef struct {
        int          n;
        bit          last;
        int          gap;
        bit          extra;
        logic [31:0] seed;
        int          exp_wc;
        bit          exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs[6];

    bit in_run = 1'b0;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
        check({tag, "_s_ready"},    64'(s_ready),    64'd1);
        check({tag, "_imem_we"},    64'(imem_we),    64'd0);
        check({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
        check({tag, "_load_error"}, 64'(load_error), 64'd0);
        check({tag, "_busy"},       64'(busy),       64'd1);
    endtask

    task automatic do_reload();
        check("pre_reload_core_reset", 64'(core_reset), 64'd0);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check("reload_core_reset", 64'(core_reset), 64'd1);
        check("reload_s_ready",    64'(s_ready),    64'd1);
        check("reload_word_count", 64'(word_count), 64'd0);
        check("reload_load_error", 64'(load_error), 64'd0);
        check("reload_busy",       64'(busy),       64'd1);
        in_run = 1'b0;
    endtask

    task automatic run_program(input vec_t v);
        int          k;
        int          w;
        bit          released;
        logic [31:0] d;
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            d       = v.seed + 32'(i) * 32'h11;
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == v.n - 1) && v.last;
            exp_q.push_back('{addr: 10'(i), data: d});
            @(posedge clk);
            #1;
        end
        k = edge_cnt;
        if (v.extra) begin
            s_valid = 1'b1;
            s_data  = 32'hDEAD_BEEF;
            s_last  = 1'b1;
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        check("last_s_ready",    64'(s_ready),    64'd0);
        check("last_core_reset", 64'(core_reset), 64'd1);
        for (int a = v.n; a < c_DEPTH; a++) begin
            exp_q.push_back('{addr: 10'(a), data: 32'h0});
        end
        released = 1'b0;
        for (w = 0; w < c_BOUND; w++) begin
            @(posedge clk);
            #1;
            reload = 1'b0;
            if (core_reset == 1'b0) begin
                released = 1'b1;
                break;
            end
            // A reload outside RUN must have no effect.
            if (w == 1) reload = 1'b1;
        end
        reload  = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!released) begin
            check("release_timeout", 64'd1, 64'd0);
        end else begin
            check("release_latency", 64'(edge_cnt - k), 64'(v.exp_lat));
        end
        check("run_word_count", 64'(word_count), 64'(v.exp_wc));
        check("run_load_error", 64'(load_error), 64'(v.exp_err));
        check("run_busy",       64'(busy),       64'd0);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        in_run = released;
    endtask

    initial begin
        int  w;
        bit  hit;

        vecs[0] = '{n: 3,    last: 1'b1, gap: 0, extra: 1'b0, seed: 32'h11,   exp_wc: 3,    exp_err: 1'b0, exp_lat: 1025};
        vecs[1] = '{n: 5,    last: 1'b1, gap: 2, extra: 1'b1, seed: 32'h100,  exp_wc: 5,    exp_err: 1'b0, exp_lat: 1023};
        vecs[2] = '{n: 1024, last: 1'b0, gap: 0, extra: 1'b0, seed: 32'h1000, exp_wc: 1024, exp_err: 1'b1, exp_lat: 4};
        vecs[3] = '{n: 1,    last: 1'b1, gap: 0, extra: 1'b0, seed: 32'hAB,   exp_wc: 1,    exp_err: 1'b0, exp_lat: 1027};
        vecs[4] = '{n: 1023, last: 1'b1, gap: 1, extra: 1'b0, seed: 32'h7,    exp_wc: 1023, exp_err: 1'b0, exp_lat: 5};
        vecs[5] = '{n: 2,    last: 1'b1, gap: 0, extra: 1'b0, seed: 32'h200,  exp_wc: 2,    exp_err: 1'b0, exp_lat: 1026};

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("idle");

        for (int t = 0; t < 5; t++) begin
            if (in_run) do_reload();
            run_program(vecs[t]);
        end

        // Asynchronous reset in the middle of the fill.
        if (in_run) do_reload();
        s_valid = 1'b1;
        s_data  = 32'h55;
        s_last  = 1'b1;
        exp_q.push_back('{addr: 10'd0, data: 32'h55});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int a = 1; a < c_DEPTH; a++) begin
            exp_q.push_back('{addr: 10'(a), data: 32'h0});
        end
        hit = 1'b0;
        for (w = 0; w < c_BOUND; w++) begin
            if (imem_we === 1'b1 && imem_addr == 10'd500) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("fill_reaches_500", 64'(hit), 64'd1);
        check("midfill_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midfill");
        exp_q.delete();
        in_run = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_program(vecs[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
